alu_result_stage: RTL

- Registered stage directly downstream of the 16-bit ALU adder.
- Captures the adder sum together with its overflow (V) and carry (C) outputs.
- Optionally saturates signed overflow, derives N/Z, holds the architectural NZCV flag register, and presents write-back data through a valid/ready handshake.
- Contains a 2-entry skid buffer so the upstream `in_ready` never depends combinationally on `wb_ready`.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/alu_skid_buf.sv | 74 +++++++
 rtl/alu_result_stage.sv | 77 +++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// The result record is the unit that moves through the write-back buffer.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
    logic [3:0]        nzcv;
    logic              flag_we;
    logic              sat;
  } alu_res_t;

  // A wrapped sum with its sign bit set came from a positive overflow.
  function automatic logic [DATA_W-1:0] sat_value(input logic wrapped_sign);
    return wrapped_sign ? SAT_POS : SAT_NEG;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream adder result and downstream write-back signals of the result stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface alu_result_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_ovf;
  logic              in_carry;
  logic [ADDR_W-1:0] in_dest;
  logic              in_sat;
  logic              in_flag_we;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_dest;
  logic [3:0]        wb_nzcv;

  modport slave (
    input  in_valid, in_sum, in_ovf, in_carry, in_dest, in_sat, in_flag_we,
    output in_ready,
    output wb_valid, wb_data, wb_dest, wb_nzcv,
    input  wb_ready
  );

  modport master (
    output in_valid, in_sum, in_ovf, in_carry, in_dest, in_sat, in_flag_we,
    input  in_ready,
    input  wb_valid, wb_data, wb_dest, wb_nzcv,
    output wb_ready
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry FIFO-ordered valid/ready buffer with a registered push_ready,
// so the upstream ready never depends combinationally on pop_ready.
//
// state    | meaning
// ST_EMPTY | no entries, pop_valid=0
// ST_ONE   | head holds the only entry
// ST_TWO   | head and tail full, push_ready=0
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         rdy;
  logic         push;
  logic         pop;

  assign push       = push_valid && rdy;
  assign pop        = (state != ST_EMPTY) && pop_ready;
  assign push_ready = rdy;
  assign pop_valid  = (state != ST_EMPTY);
  assign pop_data   = head;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (push) state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_TWO;
        else if (!push && pop) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (pop) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      rdy   <= 1'b1;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt != ST_TWO);
      case (state)
        ST_EMPTY: if (push) head <= push_data;
        ST_ONE: begin
          // Simultaneous push and pop: the new entry goes straight to the head.
          if (push && pop) head <= push_data;
          else if (push)   tail <= push_data;
        end
        ST_TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU adder: saturation, NZCV derivation,
// buffered write-back handshake and architectural flag/overflow state.
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              sat_any
);

  import alu_pkg::*;

  logic              do_sat;
  logic [DATA_W-1:0] fin_data;
  logic [ADDR_W-1:0] head_dest;
  alu_res_t          cap;
  alu_res_t          head;
  logic              commit;

  assign do_sat = bus.in_sat && bus.in_ovf;

  always_comb begin
    fin_data = bus.in_sum;
    if (do_sat) fin_data = sat_value(bus.in_sum[DATA_W-1]);
  end

  // V keeps the raw adder overflow even when the data was clamped.
  always_comb begin
    cap              = '0;
    cap.data         = fin_data;
    cap.dest         = bus.in_dest;
    cap.nzcv[FLAG_N] = fin_data[DATA_W-1];
    cap.nzcv[FLAG_Z] = (fin_data == '0);
    cap.nzcv[FLAG_C] = bus.in_carry;
    cap.nzcv[FLAG_V] = bus.in_ovf;
    cap.flag_we      = bus.in_flag_we;
    cap.sat          = do_sat;
  end

  alu_skid_buf #(
    .W($bits(alu_res_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (cap),
    .pop_valid  (bus.wb_valid),
    .pop_ready  (bus.wb_ready),
    .pop_data   (head)
  );

  assign head_dest   = head.dest;
  assign bus.wb_data = head.data;
  assign bus.wb_dest = head_dest;
  assign bus.wb_nzcv = head.nzcv;

  assign commit = bus.wb_valid && bus.wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= 4'b0000;
      ovf_count <= '0;
      sat_any   <= 1'b0;
    end else if (commit) begin
      if (head.flag_we) flags <= head.nzcv;
      if (head.nzcv[FLAG_V] && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
      if (head.sat) sat_any <= 1'b1;
    end
  end

endmodule
